i2s_rx_frontend: RTL and testbench
==================================

# i2s_rx_frontend

Serial audio capture stage feeding the adaptive notch filter. Deserializes one channel of a standard I2S stream from the codec (bclk, lrclk, sdata) into a 24-bit two's-complement sample. Presents the sample on `data_out` together with a one-cycle `sample_trig` in the `clk` domain. Holds the sample stable until the next capture, and tracks whether the filter acknowledged each sample via its `filter_done` pulse.

## Interface
- DATA_SIZE, 24, sample width in bits; equals the filter's data port width.
- CHANNEL, 0, captured channel: 0 = left (lrclk low), 1 = right (lrclk high).
- SYNC_STAGES, 2, synchronizer depth for bclk/lrclk/sdata; minimum 2.

- clk  in  1  system clock; filter clock.
- reset  in  1  asynchronous, active-high; clears all state.
- i2s_bclk  in  1  codec bit clock, asynchronous to clk.
- i2s_lrclk  in  1  codec word select, asynchronous to clk.
- i2s_sdata  in  1  codec serial data, MSB first.
- filter_done  in  1  one-cycle acknowledge from the filter.
- clear_flags  in  1  synchronous clear of `overrun` and `frame_err`.
- data_out  out  DATA_SIZE  last captured sample; connects to the filter's `data_in`.
- sample_trig  out  1  one-cycle pulse when `data_out` changes.
- overrun  out  1  sticky: a new sample was latched before the previous one was acknowledged.
- frame_err  out  1  sticky: lrclk toggled before DATA_SIZE bits were shifted in.

## Operation
- Synchronization: bclk, lrclk and sdata each pass through SYNC_STAGES flip-flops, then one extra history flip-flop.
- `bclk_rise` is a one-cycle strobe derived from the synchronized bclk (0 followed by 1).
- All lrclk and sdata sampling happens only in cycles with `bclk_rise`.
- Word-select edge: on `bclk_rise`, if lrclk differs from its value at the previous `bclk_rise`, it is a ws edge.
  - The bit on that edge is the previous word's LSB (I2S one-bit delay) and is discarded.
  - `bit_cnt` is set to 0.
  - `cur_ch` takes the new lrclk value.
- FSM states and transitions:
  - WAIT_WS (reset state): ignore data. On a ws edge go to SHIFT if `cur_ch == CHANNEL`, else go to SKIP.
  - SKIP: ignore bits. On a ws edge apply the same rule as WAIT_WS.
  - SHIFT: on each non-ws `bclk_rise`, shift sdata into `shift_reg` LSB-first-position (MSB arrives first) and increment `bit_cnt`.
    - When `bit_cnt` reaches DATA_SIZE, go to LATCH.
    - A ws edge while `bit_cnt < DATA_SIZE` sets `frame_err`, discards `shift_reg`, and re-enters via the ws-edge rule. No trigger is issued.
  - LATCH (one cycle): `data_out <= shift_reg`; `sample_trig = 1` this cycle. Go to SKIP; trailing bits of a 32-bit slot are ignored.
- Acknowledge tracking:
  - `pending` sets in the LATCH cycle.
  - `pending` clears on `filter_done`.
  - If LATCH occurs while `pending` is still 1, set `overrun`. `data_out` is still updated (newest sample wins).
  - If `filter_done` and LATCH coincide, `pending` stays 1 and no overrun is flagged.
- `clear_flags` clears both sticky flags. If a set condition occurs in the same cycle, the set wins.
- Sample is taken verbatim as two's complement; no sign extension or scaling here. The filter extends it internally.

## Timing
- Reset values:
  - outputs: `data_out` = 0, `sample_trig` = 0, `overrun` = 0, `frame_err` = 0;
  - internal: `pending` = 0, `bit_cnt` = 0, `shift_reg` = 0, synchronizers = 0, state = WAIT_WS.
- Reset mid-word: the partial word is lost. Capture resumes only after the next ws edge, so the first valid sample is the first complete word of CHANNEL after that edge.
- `sample_trig` is registered and asserted in the same cycle that `data_out` shows the new value.
- `data_out` is stable from LATCH until the next LATCH, which is at least one full frame (64 bclk) later. This is far longer than the filter's 5-cycle processing window.
- Latency: SYNC_STAGES + 2 clk cycles from the codec's bclk rise of the LSB to `sample_trig`.
- Clock ratio requirement: bclk high and low phases each ≥ SYNC_STAGES+1 clk periods. Behaviour is undefined otherwise.
- Word lengths: slots longer than DATA_SIZE bits are accepted. Slots shorter than DATA_SIZE bits produce `frame_err`.

## Test plan
- Left word 0x123456 in a 32-bit slot, right word 0xABCDEF, CHANNEL=0, `filter_done` returned 1 cycle after each trigger -> exactly one `sample_trig` per frame; `data_out` = 0x123456; flags stay 0.
- Left word 0x800001 (negative), then 0x7FFFFF -> `data_out` = 0x800001, then 0x7FFFFF, bit-exact.
- CHANNEL=1, same stream -> `data_out` = 0xABCDEF; no trigger during the left slot.
- Left slot only 16 bits long (lrclk toggles early) -> `frame_err` = 1; no `sample_trig` that frame; next full frame captures normally. `clear_flags` then returns `frame_err` to 0.
- `filter_done` held 0 across two frames carrying 0x000010 and 0x000020 -> `overrun` = 1 at the second LATCH; `data_out` = 0x000020.
- `reset` pulsed at bit 10 of a left word -> all outputs 0 immediately. The following frame produces no trigger until after a ws edge, then the next left word is captured correctly.

Source files
------------

// File: rtl/i2s_rx_frontend.sv
// I2S receive front end: synchronizes the codec bit stream into the clk domain and
// captures one channel as a DATA_SIZE-bit two's-complement sample for the notch filter.
module i2s_rx_frontend #(
    parameter int DATA_SIZE   = 24,
    parameter int CHANNEL     = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i2s_bclk,
    input  logic                 i2s_lrclk,
    input  logic                 i2s_sdata,
    input  logic                 filter_done,
    input  logic                 clear_flags,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 sample_trig,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam int   CNT_W  = $clog2(DATA_SIZE + 1);
    localparam logic CH_SEL = (CHANNEL != 0);

    typedef enum logic [1:0] {
        WAIT_WS,
        SKIP,
        SHIFT,
        LATCH
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] bclk_sync, lrclk_sync, sdata_sync;
    logic                   bclk_d, lrclk_d, sdata_d;
    logic                   bclk_rise;
    logic                   ws_edge;
    logic                   lr_prev;
    logic                   lr_seen;
    logic                   cur_ch;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_SIZE-1:0]   shift_reg;
    logic                   pending;

    logic                   shift_en;
    logic                   set_ferr;
    logic                   latch_en;

    // NOTE: every clocked process uses non-blocking assignments so all registers update
    // from pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
            sdata_sync <= '0;
            bclk_d     <= 1'b0;
            lrclk_d    <= 1'b0;
            sdata_d    <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], i2s_lrclk};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i2s_sdata};
            bclk_d     <= bclk_sync[SYNC_STAGES-1];
            lrclk_d    <= lrclk_sync[SYNC_STAGES-1];
            sdata_d    <= sdata_sync[SYNC_STAGES-1];
        end
    end

    // lrclk/sdata are read from the history stage; they settled half a bclk period earlier.
    assign bclk_rise = bclk_sync[SYNC_STAGES-1] & ~bclk_d;

    // The first rise after reset only records lrclk, so a word in progress is never
    // mistaken for a fresh word-select edge.
    assign ws_edge = bclk_rise & lr_seen & (lrclk_d ^ lr_prev);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_WS;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        set_ferr   = 1'b0;
        latch_en   = 1'b0;
        case (state)
            WAIT_WS, SKIP: begin
                if (ws_edge) begin
                    next_state = (lrclk_d == CH_SEL) ? SHIFT : SKIP;
                end
            end
            SHIFT: begin
                if (ws_edge) begin
                    set_ferr   = 1'b1;
                    next_state = (lrclk_d == CH_SEL) ? SHIFT : SKIP;
                end else if (bclk_rise && cur_ch == CH_SEL) begin
                    shift_en = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_SIZE - 1)) begin
                        next_state = LATCH;
                    end
                end
            end
            LATCH: begin
                latch_en   = 1'b1;
                next_state = SKIP;
            end
            default: next_state = WAIT_WS;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lr_prev   <= 1'b0;
            lr_seen   <= 1'b0;
            cur_ch    <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (bclk_rise) begin
                lr_prev <= lrclk_d;
                lr_seen <= 1'b1;
            end
            if (ws_edge) begin
                // The bit on the ws edge is the previous word's LSB and is dropped.
                cur_ch    <= lrclk_d;
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[DATA_SIZE-2:0], sdata_d};
                bit_cnt   <= bit_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out    <= '0;
            sample_trig <= 1'b0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sample_trig <= latch_en;
            if (latch_en) begin
                data_out <= shift_reg;
            end

            // An acknowledge landing on the latch cycle belongs to the older sample.
            if (latch_en) begin
                pending <= 1'b1;
            end else if (filter_done) begin
                pending <= 1'b0;
            end

            if (latch_en && pending && !filter_done) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end

            if (set_ferr) begin
                frame_err <= 1'b1;
            end else if (clear_flags) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Bench for i2s_rx_frontend: drives a randomized I2S stream into a left and a right
// capture instance and compares them every cycle against a word-level timing model.
module tb_i2s_rx_frontend;

    localparam int DS   = 24;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic bclk = 1'b0;
    logic lrclk = 1'b0;
    logic sdata = 1'b0;
    logic clear_flags = 1'b0;
    logic [1:0] filter_done = 2'b00;

    logic [DS-1:0] dout [2];
    logic [1:0]    trig;
    logic [1:0]    ovr;
    logic [1:0]    ferr;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        i2s_rx_frontend #(
            .DATA_SIZE  (DS),
            .CHANNEL    (g),
            .SYNC_STAGES(SYNC)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .i2s_bclk   (bclk),
            .i2s_lrclk  (lrclk),
            .i2s_sdata  (sdata),
            .filter_done(filter_done[g]),
            .clear_flags(clear_flags),
            .data_out   (dout[g]),
            .sample_trig(trig[g]),
            .overrun    (ovr[g]),
            .frame_err  (ferr[g])
        );
    end

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int tcnt [2] = '{0, 0};
    int ack_mode = 1;
    bit rand_clr = 1'b0;
    bit started = 1'b0;

    // Expected output registers per instance, and events scheduled by cycle*2+channel.
    logic [DS-1:0] m_data [2] = '{'0, '0};
    bit            m_trig [2] = '{0, 0};
    bit            m_ovr  [2] = '{0, 0};
    bit            m_ferr [2] = '{0, 0};
    bit            m_pend [2] = '{0, 0};
    logic [DS-1:0] trig_at [int];
    bit            ferr_at [int];

    // Word-level view of the stream as seen since the last reset.
    bit            armed = 1'b0;
    bit            prev_lr = 1'b0;
    bit            cap  [2] = '{0, 0};
    int            bits [2] = '{0, 0};
    logic [DS-1:0] val  [2] = '{'0, '0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                int key;
                key = cyc * 2 + k;
                if (clear_flags) begin
                    m_ovr[k]  = 1'b0;
                    m_ferr[k] = 1'b0;
                end
                if (ferr_at.exists(key)) begin
                    m_ferr[k] = 1'b1;
                    ferr_at.delete(key);
                end
                if (trig_at.exists(key)) begin
                    if (m_pend[k] && !filter_done[k]) m_ovr[k] = 1'b1;
                    m_pend[k] = 1'b1;
                    m_data[k] = trig_at[key];
                    m_trig[k] = 1'b1;
                    trig_at.delete(key);
                end else begin
                    m_trig[k] = 1'b0;
                    if (filter_done[k]) m_pend[k] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started && !reset) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d data_out", k), 32'(dout[k]), 32'(m_data[k]));
                check($sformatf("dut%0d sample_trig", k), 32'(trig[k]), 32'(m_trig[k]));
                check($sformatf("dut%0d overrun", k), 32'(ovr[k]), 32'(m_ovr[k]));
                check($sformatf("dut%0d frame_err", k), 32'(ferr[k]), 32'(m_ferr[k]));
                if (trig[k]) tcnt[k]++;
            end
        end
    end

    // Filter acknowledge and random flag-clear stimulus.
    always @(negedge clk) begin
        if (rand_clr) clear_flags = ($urandom_range(0, 63) == 0);
        for (int k = 0; k < 2; k++) begin
            case (ack_mode)
                0:       filter_done[k] = 1'b0;
                1:       filter_done[k] = trig[k];
                default: filter_done[k] = ($urandom_range(0, 7) == 0);
            endcase
        end
    end

    // One bclk rise as seen by an ideal receiver, issued at cycle c.
    task automatic model_rise(input int c, input bit lr, input bit sd);
        if (!armed) begin
            armed   = 1'b1;
            prev_lr = lr;
        end else if (lr != prev_lr) begin
            for (int k = 0; k < 2; k++) begin
                if (cap[k] && bits[k] < DS) ferr_at[(c + LAT - 1) * 2 + k] = 1'b1;
                cap[k]  = (lr == k[0]);
                bits[k] = 0;
                val[k]  = '0;
            end
            prev_lr = lr;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (cap[k]) begin
                    val[k]  = {val[k][DS-2:0], sd};
                    bits[k] = bits[k] + 1;
                    if (bits[k] == DS) begin
                        trig_at[(c + LAT) * 2 + k] = val[k];
                        cap[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    // Entered and left on a falling clk edge; phases are 3..5 clk periods.
    task automatic send_bit(input bit lr, input bit sd);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = sd;
        repeat ($urandom_range(3, 5)) @(negedge clk);
        bclk = 1'b1;
        model_rise(cyc, lr, sd);
        repeat ($urandom_range(3, 5)) @(negedge clk);
    endtask

    function automatic bit slot_bit(input logic [DS-1:0] word, input int i);
        if (i >= 1 && i <= DS) return word[DS-i];
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic send_slot(input bit lr, input logic [DS-1:0] word, input int len);
        for (int i = 0; i < len; i++) send_bit(lr, slot_bit(word, i));
    endtask

    task automatic send_frame(input logic [DS-1:0] l, input logic [DS-1:0] r,
                              input int llen = 32, input int rlen = 32);
        send_slot(1'b0, l, llen);
        send_slot(1'b1, r, rlen);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [DS-1:0] rnd_word();
        return DS'($urandom);
    endfunction

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int t0, t1;
        logic [DS-1:0] w;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset dut%0d data_out", k), 32'(dout[k]), 32'h0);
            check($sformatf("reset dut%0d sample_trig", k), 32'(trig[k]), 32'h0);
            check($sformatf("reset dut%0d overrun", k), 32'(ovr[k]), 32'h0);
            check($sformatf("reset dut%0d frame_err", k), 32'(ferr[k]), 32'h0);
        end
        reset   = 1'b0;
        started = 1'b1;
        @(negedge clk);

        // Nominal stream, acknowledge one cycle after each trigger.
        send_frame(rnd_word(), rnd_word());
        t0 = tcnt[0];
        t1 = tcnt[1];
        repeat (3) send_frame(24'h123456, 24'hABCDEF);
        settle();
        check("left word", 32'(dout[0]), 32'h123456);
        check("right word", 32'(dout[1]), 32'hABCDEF);
        check("left triggers per frame", 32'(tcnt[0] - t0), 32'd3);
        check("right triggers per frame", 32'(tcnt[1] - t1), 32'd3);
        check("nominal overrun", 32'(ovr), 32'h0);
        check("nominal frame_err", 32'(ferr), 32'h0);

        // Full-scale negative and positive words.
        send_frame(24'h800001, rnd_word());
        settle();
        check("negative word", 32'(dout[0]), 32'h800001);
        send_frame(24'h7FFFFF, rnd_word());
        settle();
        check("positive word", 32'(dout[0]), 32'h7FFFFF);

        // Short left slot.
        t0 = tcnt[0];
        send_frame(rnd_word(), rnd_word(), 16, 32);
        settle();
        check("short slot frame_err left", 32'(ferr[0]), 32'h1);
        check("short slot frame_err right", 32'(ferr[1]), 32'h0);
        check("short slot no trigger", 32'(tcnt[0] - t0), 32'd0);
        send_frame(24'h13579B, rnd_word());
        settle();
        check("after short slot word", 32'(dout[0]), 32'h13579B);
        check("after short slot trigger", 32'(tcnt[0] - t0), 32'd1);
        pulse_clear();
        check("frame_err cleared", 32'(ferr[0]), 32'h0);

        // No acknowledge across two frames.
        ack_mode = 0;
        send_frame(24'h000010, rnd_word());
        settle();
        check("first unacked no overrun", 32'(ovr[0]), 32'h0);
        send_frame(24'h000020, rnd_word());
        settle();
        check("overrun set", 32'(ovr[0]), 32'h1);
        check("newest sample wins", 32'(dout[0]), 32'h000020);
        ack_mode = 1;
        pulse_clear();
        check("overrun cleared", 32'(ovr[0]), 32'h0);

        // Reset at bit 10 of a left word.
        send_frame(rnd_word(), rnd_word());
        w = rnd_word();
        for (int i = 0; i < 11; i++) send_bit(1'b0, slot_bit(w, i));
        bclk = 1'b0;
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("mid-word reset dut%0d data_out", k), 32'(dout[k]), 32'h0);
            check($sformatf("mid-word reset dut%0d trig/flags", k),
                  32'({trig[k], ovr[k], ferr[k]}), 32'h0);
            m_data[k] = '0;
            m_trig[k] = 1'b0;
            m_ovr[k]  = 1'b0;
            m_ferr[k] = 1'b0;
            m_pend[k] = 1'b0;
            cap[k]    = 1'b0;
        end
        armed = 1'b0;
        trig_at.delete();
        ferr_at.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        t0 = tcnt[0];
        t1 = tcnt[1];
        for (int i = 11; i < 32; i++) send_bit(1'b0, slot_bit(w, i));
        send_slot(1'b1, rnd_word(), 32);
        settle();
        check("no left trigger before ws edge", 32'(tcnt[0] - t0), 32'd0);
        send_frame(24'h2468AC, 24'h55AA33);
        settle();
        check("post-reset left word", 32'(dout[0]), 32'h2468AC);
        check("post-reset right word", 32'(dout[1]), 32'h55AA33);
        check("post-reset left triggers", 32'(tcnt[0] - t0), 32'd1);
        check("post-reset right triggers", 32'(tcnt[1] - t1), 32'd2);

        // Random words, slot lengths, acknowledges and flag clears.
        ack_mode = 2;
        rand_clr = 1'b1;
        for (int f = 0; f < 20; f++) begin
            int ll, rl;
            ll = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 24) : $urandom_range(25, 32);
            rl = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 24) : $urandom_range(25, 32);
            send_frame(rnd_word(), rnd_word(), ll, rl);
        end
        rand_clr    = 1'b0;
        clear_flags = 1'b0;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not complete, expected end within bound");
        $fatal(1);
    end

endmodule
